// File: rtl/mcu_msg_pkg.sv
// Shared types and constants for the front-panel MCU message transmitter.
package mcu_msg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_DONE,
`ifdef MCU_MSG_TX_ACK_EN
    WAIT_ACK,
`endif
    NEXT
  } state_t;

  localparam logic [3:0] CMD_ACK     = 4'h1;
  localparam logic [3:0] CMD_STAGE   = 4'h2;
  localparam logic [3:0] CMD_VERSION = 4'h3;
  localparam logic [3:0] CMD_IP      = 4'h4;
  localparam logic [3:0] CMD_STATUS  = 4'h5;
  localparam logic [3:0] CMD_POWERON = 4'h6;

  // 10 ms at 122.88 MHz
  localparam int DEFAULT_ACK_TIMEOUT = 1228800;

endpackage

// File: rtl/mcu_rr_arbiter.sv
// Round-robin pick: first pending channel at or after the pointer; purely combinational.
module mcu_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   pointer,
  output logic [CH_W-1:0]   grant,
  output logic              any_valid
);

  int              idx;
  logic [CH_W-1:0] idx_c;

  // Walk offsets from the far end so the nearest pending channel is written last.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    idx_c     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(pointer) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_c = CH_W'(idx);
      if (pending[idx_c]) begin
        grant     = idx_c;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcu_msg_tx.sv
// Multi-channel framed transmitter to UART_TX: toggle requests, round-robin service, one byte in flight.
// Optional acknowledge/retry path enabled by defining MCU_MSG_TX_ACK_EN.
module mcu_msg_tx
  import mcu_msg_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                MAX_LEN     = 16,
  parameter int                LEN_W       = 5,
  parameter logic [NUM_CH-1:0] BOOT_MASK   = NUM_CH'(4'b1111),
  parameter int                ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
  parameter int                MAX_RETRY   = 2
) (
  input  logic                      clk,
  input  logic                      i_Rst_L,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_toggle,
  input  logic [NUM_CH*8-1:0]       ch_hdr,
  input  logic [NUM_CH*LEN_W-1:0]   ch_len,
  input  logic [NUM_CH*MAX_LEN*8-1:0] ch_data,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic                      uart_tx_dv,
  output logic [7:0]                uart_tx_byte,
  input  logic                      uart_tx_done,
  input  logic                      rx_dv,
  input  logic [7:0]                rx_byte,
  output logic                      msg_sent,
  output logic [3:0]                msg_ch,
  output logic                      msg_err
);

  localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int               IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t                   state, state_nxt;
  logic [NUM_CH-1:0]        pending, toggle_old, req_edge, take;
  logic [CH_W-1:0]          rr_ptr, cur_ch, grant, ch_after;
  logic                     any_valid;
  logic [7:0]               hdr_q, cur_byte;
  logic [MAX_LEN-1:0][7:0]  data_q;
  logic [LEN_W-1:0]         len_q, cnt, raw_len, len_clamped;
  logic [IDX_W-1:0]         byte_idx;
  logic                     start, cnt_inc, advance, resend;

  mcu_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .pending   (pending),
    .pointer   (rr_ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign req_edge    = ch_toggle ^ toggle_old;
  assign take        = start ? (NUM_CH'(1) << grant) : '0;
  assign ch_after    = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
  assign raw_len     = ch_len[cur_ch*LEN_W +: LEN_W];
  assign len_clamped = (raw_len > LEN_MAX) ? LEN_MAX : raw_len;
  assign byte_idx    = IDX_W'(cnt - 1'b1);
  assign cur_byte    = (cnt == '0) ? hdr_q : data_q[byte_idx];

  assign ch_busy      = pending | ((state != IDLE) ? (NUM_CH'(1) << cur_ch) : '0);
  assign uart_tx_dv   = (state == SEND);
  assign uart_tx_byte = (state == SEND) ? cur_byte : 8'h00;
  assign msg_sent     = (state == NEXT);
  assign msg_ch       = 4'(cur_ch);

`ifdef MCU_MSG_TX_ACK_EN
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic [RTY_W-1:0] retry;
  logic             ack_hit, timeout, drop, msg_err_q;

  assign ack_hit = rx_dv && (rx_byte == {CMD_ACK, 4'(cur_ch)});
  assign timeout = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
  // Registered so msg_err lands in the IDLE cycle while msg_ch still names the dropped channel.
  assign msg_err = msg_err_q;

  always_ff @(posedge clk) begin
    if (!i_Rst_L) begin
      tmo_cnt   <= '0;
      retry     <= '0;
      msg_err_q <= 1'b0;
    end else begin
      msg_err_q <= drop;
      if (state == WAIT_ACK) tmo_cnt <= tmo_cnt + 1'b1;
      else                   tmo_cnt <= '0;
      if (state == LOAD)     retry <= '0;
      else if (resend)       retry <= retry + 1'b1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{rx_dv, rx_byte, 32'(ACK_TIMEOUT), 32'(MAX_RETRY)};
  assign msg_err   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    cnt_inc   = 1'b0;
    advance   = 1'b0;
    resend    = 1'b0;
`ifdef MCU_MSG_TX_ACK_EN
    drop      = 1'b0;
`endif
    case (state)
      IDLE: if (enable && any_valid) begin
        start     = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: state_nxt = SEND;
      SEND: state_nxt = WAIT_DONE;
      WAIT_DONE: if (uart_tx_done) begin
        if (cnt < len_q) begin
          cnt_inc   = 1'b1;
          state_nxt = SEND;
        end else begin
`ifdef MCU_MSG_TX_ACK_EN
          state_nxt = WAIT_ACK;
`else
          state_nxt = NEXT;
`endif
        end
      end
`ifdef MCU_MSG_TX_ACK_EN
      WAIT_ACK: if (ack_hit) begin
        state_nxt = NEXT;
      end else if (timeout) begin
        if (retry < RTY_W'(MAX_RETRY)) begin
          resend    = 1'b1;
          state_nxt = SEND;
        end else begin
          drop      = 1'b1;
          advance   = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      NEXT: begin
        advance   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_Rst_L) begin
      state      <= IDLE;
      pending    <= BOOT_MASK;
      toggle_old <= ch_toggle;
      rr_ptr     <= '0;
      cur_ch     <= '0;
      hdr_q      <= '0;
      data_q     <= '0;
      len_q      <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      toggle_old <= ch_toggle;
      // A fresh edge wins over the grant clear so a re-request is never lost.
      pending    <= (pending & ~take) | req_edge;
      if (start) cur_ch <= grant;
      if (state == LOAD) begin
        hdr_q  <= ch_hdr[cur_ch*8 +: 8];
        data_q <= ch_data[cur_ch*MAX_LEN*8 +: MAX_LEN*8];
        len_q  <= len_clamped;
        cnt    <= '0;
      end else if (resend) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (advance) rr_ptr <= ch_after;
    end
  end

endmodule

// File: tb/tb_mcu_msg_tx.sv
// Directed bench for mcu_msg_tx: UART model answers each strobe with done 20 cycles later.
module tb_mcu_msg_tx;

  localparam int NUM_CH  = 4;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int DONE_DLY = 20;

  logic                        clk = 1'b0;
  logic                        i_Rst_L = 1'b0;
  logic                        enable = 1'b0;
  logic [NUM_CH-1:0]           ch_toggle = '0;
  logic [NUM_CH*8-1:0]         ch_hdr = '0;
  logic [NUM_CH*LEN_W-1:0]     ch_len = '0;
  logic [NUM_CH*MAX_LEN*8-1:0] ch_data = '0;
  logic [NUM_CH-1:0]           ch_busy;
  logic                        uart_tx_dv;
  logic [7:0]                  uart_tx_byte;
  logic                        uart_tx_done = 1'b0;
  logic                        rx_dv = 1'b0;
  logic [7:0]                  rx_byte = 8'h00;
  logic                        msg_sent;
  logic [3:0]                  msg_ch;
  logic                        msg_err;

  int errors = 0;
  int checks = 0;
  logic [7:0] tx_q[$];
  logic [3:0] sent_q[$];
  logic [3:0] err_q[$];
  bit auto_ack = 1'b1;

  mcu_msg_tx #(
    .NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .BOOT_MASK(4'b0101),
    .ACK_TIMEOUT(100), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .i_Rst_L(i_Rst_L), .enable(enable), .ch_toggle(ch_toggle),
    .ch_hdr(ch_hdr), .ch_len(ch_len), .ch_data(ch_data), .ch_busy(ch_busy),
    .uart_tx_dv(uart_tx_dv), .uart_tx_byte(uart_tx_byte), .uart_tx_done(uart_tx_done),
    .rx_dv(rx_dv), .rx_byte(rx_byte), .msg_sent(msg_sent), .msg_ch(msg_ch), .msg_err(msg_err)
  );

  always #4 clk = ~clk;

  // UART_TX model plus an optional responder that acks every channel after each done.
  initial begin
    int done_cnt;
    int ack_left;
    done_cnt = 0;
    ack_left = 0;
    forever begin
      @(negedge clk);
      uart_tx_done = 1'b0;
      if (auto_ack) rx_dv = 1'b0;
      if (auto_ack && ack_left > 0) begin
        rx_dv    = 1'b1;
        rx_byte  = {4'h1, 4'(4 - ack_left)};
        ack_left = ack_left - 1;
      end
      if (done_cnt > 0) begin
        done_cnt = done_cnt - 1;
        if (done_cnt == 0) begin
          uart_tx_done = 1'b1;
          ack_left     = 4;
        end
      end
      if (uart_tx_dv) done_cnt = DONE_DLY;
    end
  end

  initial forever begin
    @(negedge clk);
    if (uart_tx_dv) tx_q.push_back(uart_tx_byte);
    if (msg_sent)   sent_q.push_back(msg_ch);
    if (msg_err)    err_q.push_back(msg_ch);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) begin @(negedge clk); #1; end
  endtask

  task automatic wait_sent(input int n, input int budget);
    for (int i = 0; i < budget && sent_q.size() < n; i++) begin @(negedge clk); #1; end
  endtask

  task automatic clear_q();
    tx_q.delete(); sent_q.delete(); err_q.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hdr[i*8 +: 8] = 8'hA0 + 8'(i);
      for (int k = 0; k < MAX_LEN; k++) ch_data[(i*MAX_LEN + k)*8 +: 8] = 8'(16*i + k);
    end
    ch_len[0*LEN_W +: LEN_W] = 5'd4;
    ch_len[2*LEN_W +: LEN_W] = 5'd0;
    cyc(3);
    checks++; if (uart_tx_dv !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", uart_tx_dv); end
    checks++; if (msg_sent !== 1'b0 || msg_err !== 1'b0) begin errors++; $display("FAIL reset_msg: got sent=%b err=%b want 0 0", msg_sent, msg_err); end
    checks++; if (msg_ch !== 4'd0) begin errors++; $display("FAIL reset_msg_ch: got %0d want 0", msg_ch); end
    checks++; if (ch_busy !== 4'b0101) begin errors++; $display("FAIL reset_busy: got %b want 0101", ch_busy); end
    i_Rst_L = 1'b1;
    cyc(5);
    checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL reset_no_tx_disabled: got %0d bytes want 0", tx_q.size()); end
  endtask

  task automatic test_boot();
    clear_q();
    enable = 1'b1;
    wait_sent(2, 1000);
    cyc(20);
    checks++; if (tx_q.size() != 6) begin errors++; $display("FAIL boot_dv_count: got %0d want 6", tx_q.size()); end
    if (tx_q.size() == 6) begin
      checks++; if (tx_q[0] !== 8'hA0) begin errors++; $display("FAIL boot_hdr0: got %h want a0", tx_q[0]); end
      checks++; if (tx_q[1] !== 8'h00 || tx_q[4] !== 8'h03) begin errors++; $display("FAIL boot_data: got %h..%h want 00..03", tx_q[1], tx_q[4]); end
      checks++; if (tx_q[5] !== 8'hA2) begin errors++; $display("FAIL boot_hdr2: got %h want a2", tx_q[5]); end
    end
    checks++; if (sent_q.size() != 2) begin errors++; $display("FAIL boot_sent_count: got %0d want 2", sent_q.size()); end
    else begin
      checks++; if (sent_q[0] !== 4'd0 || sent_q[1] !== 4'd2) begin errors++; $display("FAIL boot_sent_order: got %0d,%0d want 0,2", sent_q[0], sent_q[1]); end
    end
  endtask

  task automatic test_coalesce();
    clear_q();
    ch_len[1*LEN_W +: LEN_W] = 5'd2;
    ch_toggle[0] = ~ch_toggle[0];
    wait_tx(1, 100);
    for (int i = 0; i < 3; i++) begin ch_toggle[1] = ~ch_toggle[1]; cyc(1); end
    checks++; if (ch_busy[1] !== 1'b1) begin errors++; $display("FAIL coal_busy_pending: got %b want 1", ch_busy[1]); end
    wait_sent(1, 500);
    checks++; if (ch_busy[1] !== 1'b1) begin errors++; $display("FAIL coal_busy_after_ch0: got %b want 1", ch_busy[1]); end
    wait_sent(2, 500);
    cyc(1);
    checks++; if (ch_busy[1] !== 1'b0) begin errors++; $display("FAIL coal_busy_clear: got %b want 0", ch_busy[1]); end
    cyc(200);
    checks++; if (sent_q.size() != 2) begin errors++; $display("FAIL coal_sent_count: got %0d want 2", sent_q.size()); end
    else begin
      checks++; if (sent_q[0] !== 4'd0 || sent_q[1] !== 4'd1) begin errors++; $display("FAIL coal_order: got %0d,%0d want 0,1", sent_q[0], sent_q[1]); end
    end
    checks++; if (tx_q.size() != 8) begin errors++; $display("FAIL coal_bytes: got %0d want 8", tx_q.size()); end
    else begin
      checks++; if (tx_q[5] !== 8'hA1 || tx_q[7] !== 8'h11) begin errors++; $display("FAIL coal_ch1_bytes: got %h,%h want a1,11", tx_q[5], tx_q[7]); end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_ch[4];
    exp_ch = '{4'd2, 4'd3, 4'd0, 4'd1};
    clear_q();
    ch_len = '0;
    ch_toggle = ~ch_toggle;
    wait_sent(4, 1000);
    checks++; if (sent_q.size() != 4) begin errors++; $display("FAIL simul_count: got %0d want 4", sent_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (sent_q[i] !== exp_ch[i] || tx_q[i] !== (8'hA0 + 8'(exp_ch[i]))) begin
        errors++; $display("FAIL simul_order[%0d]: got ch %0d hdr %h want ch %0d", i, sent_q[i], tx_q[i], exp_ch[i]);
      end
    end
  endtask

  task automatic test_clamp_snapshot();
    clear_q();
    ch_len[3*LEN_W +: LEN_W] = 5'd31;
    ch_toggle[3] = ~ch_toggle[3];
    wait_tx(3, 200);
    ch_hdr[3*8 +: 8] = 8'hFF;
    ch_data[3*MAX_LEN*8 +: MAX_LEN*8] = '1;
    wait_sent(1, 1500);
    cyc(30);
    checks++; if (tx_q.size() != 17) begin errors++; $display("FAIL clamp_count: got %0d want 17", tx_q.size()); end
    else begin
      checks++; if (tx_q[0] !== 8'hA3) begin errors++; $display("FAIL clamp_hdr: got %h want a3", tx_q[0]); end
      for (int k = 1; k < 17; k++) begin
        checks++; if (tx_q[k] !== 8'(8'h30 + k - 1)) begin errors++; $display("FAIL clamp_byte[%0d]: got %h want %h", k, tx_q[k], 8'(8'h30 + k - 1)); end
      end
    end
    ch_hdr[3*8 +: 8] = 8'hA3;
    for (int k = 0; k < MAX_LEN; k++) ch_data[(3*MAX_LEN + k)*8 +: 8] = 8'(48 + k);
    ch_len[3*LEN_W +: LEN_W] = 5'd0;
  endtask

  task automatic test_enable_gate();
    int lat;
    clear_q();
    enable = 1'b0;
    ch_toggle[1] = ~ch_toggle[1];
    cyc(50);
    checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL gate_no_dv: got %0d bytes want 0", tx_q.size()); end
    checks++; if (ch_busy !== 4'b0010) begin errors++; $display("FAIL gate_busy: got %b want 0010", ch_busy); end
    enable = 1'b1;
    lat = 99;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); #1;
      if (tx_q.size() > 0) begin lat = i; break; end
    end
    checks++; if (lat > 3) begin errors++; $display("FAIL gate_latency: got %0d cycles want <=3", lat); end
    wait_sent(1, 200);
    checks++; if (sent_q.size() != 1 || sent_q[0] !== 4'd1) begin errors++; $display("FAIL gate_sent: got %0d msgs want one on ch1", sent_q.size()); end
  endtask

`ifdef MCU_MSG_TX_ACK_EN
  task automatic test_ack_retry();
    clear_q();
    auto_ack = 1'b0;
    rx_dv = 1'b0;
    ch_toggle[2] = ~ch_toggle[2];
    for (int i = 0; i < 1500 && err_q.size() == 0; i++) cyc(1);
    cyc(20);
    checks++; if (tx_q.size() != 3) begin errors++; $display("FAIL ack_retry_count: got %0d want 3", tx_q.size()); end
    checks++; if (err_q.size() != 1 || err_q[0] !== 4'd2) begin errors++; $display("FAIL ack_err: got %0d errs want one on ch2", err_q.size()); end
    checks++; if (sent_q.size() != 0) begin errors++; $display("FAIL ack_no_sent: got %0d want 0", sent_q.size()); end
    clear_q();
    ch_toggle[2] = ~ch_toggle[2];
    wait_tx(2, 400);
    cyc(25);
    rx_byte = 8'h13; rx_dv = 1'b1; cyc(1);
    rx_byte = 8'h12; cyc(1);
    rx_dv = 1'b0;
    wait_sent(1, 400);
    cyc(20);
    checks++; if (sent_q.size() != 1 || sent_q[0] !== 4'd2) begin errors++; $display("FAIL ack_sent: got %0d msgs want one on ch2", sent_q.size()); end
    checks++; if (err_q.size() != 0 || tx_q.size() != 2) begin errors++; $display("FAIL ack_second: got errs=%0d bytes=%0d want 0 and 2", err_q.size(), tx_q.size()); end
    auto_ack = 1'b1;
  endtask
`endif

  task automatic test_reset_mid_frame();
    clear_q();
    ch_len[0*LEN_W +: LEN_W] = 5'd4;
    ch_toggle[0] = ~ch_toggle[0];
    wait_tx(2, 200);
    i_Rst_L = 1'b0;
    enable  = 1'b0;
    cyc(2);
    checks++; if (ch_busy !== 4'b0101) begin errors++; $display("FAIL midrst_busy: got %b want 0101", ch_busy); end
    i_Rst_L = 1'b1;
    cyc(60);
    checks++; if (tx_q.size() != 2) begin errors++; $display("FAIL midrst_no_dv: got %0d bytes want 2", tx_q.size()); end
    checks++; if (ch_busy !== 4'b0101) begin errors++; $display("FAIL midrst_busy_after: got %b want 0101", ch_busy); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_coalesce();
    test_simultaneous();
    test_clamp_snapshot();
    test_enable_gate();
`ifdef MCU_MSG_TX_ACK_EN
    test_ack_retry();
`endif
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcu_msg_tx.md
Name: mcu_msg_tx

Overview:
- Parametrised, multi-channel message transmitter toward the front-panel MCU over the existing byte-level UART_TX core.
- Replaces hand-coded per-command send states with generic channels; each channel is one command type (header byte plus 0..MAX_LEN payload bytes).
- Channels are triggered by toggle requests, arbitrated round-robin, and serialised one frame at a time.
- Sits between the bootloader/radio status logic and UART_TX, and shares the UART RX byte stream for optional acknowledgements.

Parameters:
- NUM_CH, 4, number of message channels (1..16).
- MAX_LEN, 16, maximum payload bytes per frame, header excluded.
- LEN_W, 5, width of each length field; must satisfy 2**LEN_W > MAX_LEN.
- BOOT_MASK, 4'b1111, channels marked pending when leaving reset (first-start announcement).
- ACK_TIMEOUT, 1228800, clock cycles to wait for an ack (10 ms at 122.88 MHz).
- MAX_RETRY, 2, retransmissions after the first attempt before a frame is dropped.

Ports:
- clk  in  1  122.88 MHz system clock
- i_Rst_L  in  1  synchronous, active-low reset
- enable  in  1  gate for starting frames (eeprom read complete)
- ch_toggle  in  NUM_CH  per-channel request; any edge requests a send
- ch_hdr  in  NUM_CH*8  command byte per channel
- ch_len  in  NUM_CH*LEN_W  payload length per channel
- ch_data  in  NUM_CH*MAX_LEN*8  payload; byte 0 is at the LSBs of the channel slice
- ch_busy  out  NUM_CH  channel pending or in flight
- uart_tx_dv  out  1  byte strobe to UART_TX
- uart_tx_byte  out  8  byte to UART_TX
- uart_tx_done  in  1  UART_TX byte-complete pulse
- rx_dv  in  1  UART_RX byte-valid pulse
- rx_byte  in  8  UART_RX byte
- msg_sent  out  1  one-cycle pulse: frame completed
- msg_ch  out  4  channel index qualified by msg_sent/msg_err
- msg_err  out  1  one-cycle pulse: frame dropped after retries (ack build only)

Behaviour:
- Reset (i_Rst_L=0 at a clk edge):
  - uart_tx_dv=0, uart_tx_byte=0, msg_sent=0, msg_err=0, msg_ch=0.
  - State=IDLE, RR pointer=0.
  - pending=BOOT_MASK; toggle_old<=ch_toggle, so stale edges are ignored.
  - Reset mid-frame abandons the frame with no further strobes.
- Request detect: ch_toggle[i]!=toggle_old[i] sets pending[i] and updates toggle_old[i].
  - Multiple edges while pending coalesce into one frame.
  - An edge on the in-flight channel re-pends it; it is resent later with a fresh snapshot.
- ch_busy[i] = pending[i] | (in flight and current channel==i).
- FSM states: IDLE, LOAD, SEND, WAIT_DONE, WAIT_ACK, NEXT.
  - IDLE: if enable and any pending -> pick the first pending channel at or after the RR pointer; clear its pending bit; -> LOAD.
  - LOAD: snapshot hdr, data and len for the chosen channel.
    - len is clamped to MAX_LEN.
    - byte counter=0, retry count=0.
    - -> SEND.
  - SEND: drive uart_tx_byte (counter 0 = header, k = data byte k-1); pulse uart_tx_dv for exactly one cycle; -> WAIT_DONE.
  - WAIT_DONE: on uart_tx_done:
    - if counter<len: counter+1 -> SEND (next strobe 1 cycle after done);
    - else -> WAIT_ACK (ack build) or NEXT.
  - NEXT: pulse msg_sent with msg_ch; RR pointer = channel+1 mod NUM_CH; -> IDLE.
- enable low mid-frame: the frame completes; no new frame starts until enable is high.
- Frame length = len+1 bytes. len=0 is a header-only frame.
- Input changes after LOAD do not affect the frame in flight.
- Simultaneous toggle edges are all captured in the same cycle; service order is RR.
- uart_tx_done outside WAIT_DONE is ignored.

Optional Feature:
- Macro: MCU_MSG_TX_ACK_EN.
- Defined:
  - WAIT_ACK waits up to ACK_TIMEOUT cycles for rx_dv with rx_byte=={4'h1, channel[3:0]}; other rx bytes are ignored.
  - Ack received -> NEXT.
  - Timeout with retry<MAX_RETRY -> retry+1, counter=0, resend the same snapshot (SEND).
  - Timeout at MAX_RETRY -> pulse msg_err with msg_ch, no msg_sent, advance RR, -> IDLE.
- Undefined: WAIT_ACK, the retry counter and the timeout counter are absent; msg_err is tied 0; rx ports are unused.

Decomposition:
- Package mcu_msg_pkg holds:
  - FSM state encoding.
  - Command nibbles: CMD_ACK=4'h1, CMD_STAGE=4'h2, CMD_VERSION=4'h3, CMD_IP=4'h4, CMD_STATUS=4'h5, CMD_POWERON=4'h6.
  - Default timeout constant.
- Sub-module mcu_rr_arbiter (NUM_CH): combinational first-pending-from-pointer search. Inputs: pending, pointer. Outputs: grant index, any_valid.

Test Plan:
- Reset with BOOT_MASK=4'b0101, enable=1, ch0 len=4, ch2 len=0 (UART model: done 20 cycles after dv) -> bytes hdr0,d0..d3 then hdr2; msg_sent twice with msg_ch=0 then 2; 6 dv pulses total.
- Toggle ch1 three times while ch0 is in flight -> ch1 sent exactly once after ch0; ch_busy[1]=1 until its msg_sent.
- Toggle ch0..ch3 in the same cycle with RR pointer=2 -> service order 2,3,0,1.
- ch_len=31 with MAX_LEN=16 -> exactly 17 bytes sent; change ch_data mid-frame -> transmitted bytes equal the LOAD snapshot.
- enable=0 with pending set -> no dv; enable=1 -> first dv within 3 cycles. Assert reset mid-frame -> dv stays 0, ch_busy=BOOT_MASK.
- MCU_MSG_TX_ACK_EN, ACK_TIMEOUT=100: no ack -> frame sent 3 times, then msg_err; ack 8'h12 for ch2 on the second attempt -> msg_sent, no msg_err.
